// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: per-bit output enable, synchronised inputs,
// atomic set/clear/toggle of the output register and a maskable rising-edge interrupt.
module iomem_gpio #(
    parameter int         NGPIO       = 8,
    parameter logic [7:0] BASE_HI     = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [NGPIO-1:0] gpio_in,
    output logic [NGPIO-1:0] gpio_out,
    output logic [NGPIO-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] W_OUT  = 3'd0;
    localparam logic [2:0] W_DIR  = 3'd1;
    localparam logic [2:0] W_IN   = 3'd2;
    localparam logic [2:0] W_SET  = 3'd3;
    localparam logic [2:0] W_CLR  = 3'd4;
    localparam logic [2:0] W_TGL  = 3'd5;
    localparam logic [2:0] W_IEN  = 3'd6;
    localparam logic [2:0] W_STAT = 3'd7;

    logic                              ready_reg;
    logic [31:0]                       rdata_reg, rdata_next;
    logic [NGPIO-1:0]                  out_reg, out_next;
    logic [NGPIO-1:0]                  dir_reg, dir_next;
    logic [NGPIO-1:0]                  ien_reg, ien_next;
    logic [NGPIO-1:0]                  stat_reg, stat_next;
    logic [SYNC_STAGES-1:0][NGPIO-1:0] sync_reg;
    logic [NGPIO-1:0]                  prev_reg;
    logic [NGPIO-1:0]                  sync_in, edge_det;

    logic        hit, is_write, in_map;
    logic [2:0]  word;
    logic [31:0] lane_mask;
    logic [NGPIO-1:0] wmask, wbits;
    logic        unused_ok;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{iomem_wstrb[gi]}};
        end
    endgenerate

    // The ready gate makes a held valid re-trigger only every other cycle.
    assign hit      = iomem_valid && !ready_reg && (iomem_addr[31:24] == BASE_HI);
    assign is_write = |iomem_wstrb;
    assign in_map   = (iomem_addr[7:5] == 3'b000);
    assign word     = iomem_addr[4:2];
    assign wmask    = lane_mask[NGPIO-1:0];
    assign wbits    = iomem_wdata[NGPIO-1:0] & wmask;

    assign sync_in  = sync_reg[SYNC_STAGES-1];
    assign edge_det = sync_in & ~prev_reg;

    assign unused_ok = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, lane_mask};

    always_comb begin
        out_next   = out_reg;
        dir_next   = dir_reg;
        ien_next   = ien_reg;
        stat_next  = stat_reg | edge_det;
        rdata_next = '0;
        if (hit && in_map) begin
            if (is_write) begin
                case (word)
                    W_OUT:   out_next  = (out_reg & ~wmask) | wbits;
                    W_DIR:   dir_next  = (dir_reg & ~wmask) | wbits;
                    W_SET:   out_next  = out_reg | wbits;
                    W_CLR:   out_next  = out_reg & ~wbits;
                    W_TGL:   out_next  = out_reg ^ wbits;
                    W_IEN:   ien_next  = (ien_reg & ~wmask) | wbits;
                    // A fresh edge on a bit being cleared keeps it set.
                    W_STAT:  stat_next = (stat_reg & ~wbits) | edge_det;
                    default: ;
                endcase
            end else begin
                case (word)
                    W_OUT:   rdata_next[NGPIO-1:0] = out_reg;
                    W_DIR:   rdata_next[NGPIO-1:0] = dir_reg;
                    W_IN:    rdata_next[NGPIO-1:0] = sync_in;
                    W_IEN:   rdata_next[NGPIO-1:0] = ien_reg;
                    W_STAT:  rdata_next[NGPIO-1:0] = stat_reg;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_reg <= 1'b0;
            rdata_reg <= '0;
            out_reg   <= '0;
            dir_reg   <= '0;
            ien_reg   <= '0;
            stat_reg  <= '0;
            sync_reg  <= '0;
            prev_reg  <= '0;
        end else begin
            ready_reg <= hit;
            rdata_reg <= rdata_next;
            out_reg   <= out_next;
            dir_reg   <= dir_next;
            ien_reg   <= ien_next;
            stat_reg  <= stat_next;
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], gpio_in};
            prev_reg  <= sync_in;
        end
    end

    assign iomem_ready = ready_reg;
    assign iomem_rdata = rdata_reg;
    assign gpio_out    = out_reg;
    assign gpio_oe     = dir_reg;
    assign irq         = |(stat_reg & ien_reg);

endmodule

// File: tb/tb_iomem_gpio.sv
// Bench for iomem_gpio: directed scenarios plus randomized bus/pin traffic checked
// against a register-level reference model.
module tb_iomem_gpio;

    localparam int          NG   = 8;
    localparam logic [31:0] MASK = 32'h0000_00FF;
    localparam logic [7:0]  BASE = 8'h03;

    logic          clk = 1'b0;
    logic          reset;
    logic          iomem_valid;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb;
    logic [31:0]   iomem_addr;
    logic [31:0]   iomem_wdata;
    logic [31:0]   iomem_rdata;
    logic [NG-1:0] gpio_in;
    logic [NG-1:0] gpio_out;
    logic [NG-1:0] gpio_oe;
    logic          irq;

    int total = 0;
    int bad   = 0;

    // Reference model state, 32-bit views of the registers and the settled pins.
    logic [31:0] m_out, m_dir, m_en, m_stat, m_pins;

    iomem_gpio #(.NGPIO(NG), .BASE_HI(BASE), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Issues one access, expecting the ack on the first edge after valid.
    task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        if (iomem_ready === 1'b1) begin
            @(posedge clk); #1;
        end
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        iomem_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (iomem_ready !== 1'b1) begin
            bad++;
            $display("FAIL ack_latency addr=%h: ready=%b, required 1 one cycle after valid", addr, iomem_ready);
            for (int i = 0; i < 8 && iomem_ready !== 1'b1; i++) begin
                @(posedge clk); #1;
            end
        end
        rdata       = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        if (off[7:5] != 3'd0) return 32'h0;
        case (off[4:2])
            3'd0:    return m_out;
            3'd1:    return m_dir;
            3'd2:    return m_pins;
            3'd6:    return m_en;
            3'd7:    return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] m, v;
        m = lanes(s) & MASK;
        v = d & m;
        if (off[7:5] == 3'd0) begin
            case (off[4:2])
                3'd0: m_out  = (m_out & ~m) | v;
                3'd1: m_dir  = (m_dir & ~m) | v;
                3'd3: m_out  = m_out | v;
                3'd4: m_out  = m_out & ~v;
                3'd5: m_out  = m_out ^ v;
                3'd6: m_en   = (m_en & ~m) | v;
                3'd7: m_stat = m_stat & ~v;
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        gpio_in     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        m_out = 0; m_dir = 0; m_en = 0; m_stat = 0; m_pins = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [7:0]  offs [4] = '{8'h00, 8'h04, 8'h18, 8'h1C};
        do_reset();
        total++;
        if ({iomem_ready, iomem_rdata, gpio_out, gpio_oe, irq} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b rdata=%h out=%h oe=%h irq=%b, required all 0",
                     iomem_ready, iomem_rdata, gpio_out, gpio_oe, irq);
        end
        foreach (offs[i]) begin
            bus({BASE, 16'h0, offs[i]}, 4'h0, 32'h0, rd);
            total++;
            if (rd !== 32'h0) begin
                bad++;
                $display("FAIL reset_read off=%h: got %h, required 0", offs[i], rd);
            end
        end
    endtask

    task automatic test_out_ops();
        logic [31:0] rd;
        logic [7:0]  offs [4] = '{8'h00, 8'h0C, 8'h10, 8'h14};
        logic [31:0] data [4] = '{32'hA5, 32'h0F, 32'h81, 32'hFF};
        logic [7:0]  exp  [4] = '{8'hA5, 8'hAF, 8'h2E, 8'hD1};
        foreach (offs[i]) begin
            bus({BASE, 16'h0, offs[i]}, 4'b0001, data[i], rd);
            total++;
            if (gpio_out !== exp[i]) begin
                bad++;
                $display("FAIL out_op off=%h: gpio_out=%h, required %h", offs[i], gpio_out, exp[i]);
            end
        end
        bus({BASE, 24'h00000C}, 4'h0, 32'h0, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL read_set: got %h, required 0", rd);
        end
        bus({BASE, 24'h000000}, 4'b1110, 32'hFFFF_FF00, rd);
        total++;
        if (gpio_out !== 8'hD1) begin
            bad++;
            $display("FAIL out_strobe: gpio_out=%h, required d1", gpio_out);
        end
    endtask

    task automatic test_input_irq();
        logic [31:0] rd_a, rd_b, rd;
        bus({BASE, 24'h000004}, 4'b0001, 32'hF0, rd);
        total++;
        if (gpio_oe !== 8'hF0) begin
            bad++;
            $display("FAIL dir: gpio_oe=%h, required f0", gpio_oe);
        end
        gpio_in[3] = 1'b1;
        bus({BASE, 24'h000008}, 4'h0, 32'h0, rd_a);
        bus({BASE, 24'h000008}, 4'h0, 32'h0, rd_b);
        total++;
        if (rd_a !== 32'h0) begin
            bad++;
            $display("FAIL in_early: got %h, required 0", rd_a);
        end
        total++;
        if (rd_b !== 32'h08) begin
            bad++;
            $display("FAIL in_sync: got %h, required 08", rd_b);
        end
        bus({BASE, 24'h00001C}, 4'h0, 32'h0, rd);
        total++;
        if (rd !== 32'h08 || irq !== 1'b0) begin
            bad++;
            $display("FAIL stat_edge: stat=%h irq=%b, required 08 and 0", rd, irq);
        end
        bus({BASE, 24'h000018}, 4'b0001, 32'h08, rd);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_enable: irq=%b, required 1", irq);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd;
        gpio_in[3] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        gpio_in[3] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus({BASE, 24'h00001C}, 4'b0001, 32'h08, rd);
        bus({BASE, 24'h00001C}, 4'h0, 32'h0, rd);
        total++;
        if (rd !== 32'h08 || irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_race: stat=%h irq=%b, required 08 and 1", rd, irq);
        end
        bus({BASE, 24'h00001C}, 4'b0001, 32'h08, rd);
        bus({BASE, 24'h00001C}, 4'h0, 32'h0, rd);
        total++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_clear: stat=%h irq=%b, required 0 and 0", rd, irq);
        end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        logic        seen;
        logic [7:0]  out_before;
        logic [5:0]  pat;
        @(posedge clk); #1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | iomem_ready;
        end
        iomem_valid = 1'b0;
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL decode_miss: ready=%b seen, required never", seen);
        end
        bus(32'h0300_0020, 4'h0, 32'h0, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL hole_read: got %h, required 0", rd);
        end
        out_before = gpio_out;
        bus(32'h0300_0020, 4'hF, 32'hFFFF_FFFF, rd);
        total++;
        if (gpio_out !== out_before) begin
            bad++;
            $display("FAIL hole_write: gpio_out=%h, required %h", gpio_out, out_before);
        end
        @(posedge clk); #1;
        iomem_addr  = 32'h0300_0000;
        iomem_valid = 1'b1;
        pat[0] = iomem_ready;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i] = iomem_ready;
        end
        iomem_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (pat !== 6'b101010) begin
            bad++;
            $display("FAIL held_valid: pattern(bit0 first)=%b, required 101010", pat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic        acked;
        bus({BASE, 24'h000000}, 4'b0001, 32'hFF, rd);
        @(posedge clk); #1;
        iomem_addr  = {BASE, 24'h000000};
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        total++;
        if (gpio_out !== 8'h00 || gpio_oe !== 8'h00 || irq !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: out=%h oe=%h irq=%b, required 0 immediately", gpio_out, gpio_oe, irq);
        end
        @(posedge clk); #1;
        acked = iomem_ready;
        iomem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        acked = acked | iomem_ready;
        total++;
        if (acked !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_ack: ready=%b, required 0", acked);
        end
        bus({BASE, 24'h000000}, 4'h0, 32'h0, rd);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL reissue_read: got %h, required 0", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, exp;
        logic [7:0]  off;
        logic [3:0]  s;
        logic [15:0] mid;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            off = {($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                   3'($urandom_range(0, 7)), 2'b00};
            mid = 16'($urandom);
            case ($urandom_range(0, 9))
                7, 8: begin
                    exp = model_read(off);
                    bus({BASE, mid, off}, 4'h0, 32'h0, rd);
                    total++;
                    if (rd !== exp) begin
                        bad++;
                        $display("FAIL rand_read n=%0d off=%h: got %h, required %h", n, off, rd, exp);
                    end
                end
                9: begin
                    d = $urandom & MASK;
                    gpio_in = d[NG-1:0];
                    repeat (4) @(posedge clk);
                    #1;
                    m_stat = m_stat | (d & ~m_pins);
                    m_pins = d;
                end
                default: begin
                    s = 4'($urandom_range(1, 15));
                    d = $urandom;
                    model_write(off, s, d);
                    bus({BASE, mid, off}, s, d, rd);
                end
            endcase
            total++;
            if ({gpio_out, gpio_oe, irq} !== {m_out[NG-1:0], m_dir[NG-1:0], |(m_stat & m_en)}) begin
                bad++;
                $display("FAIL rand_pins n=%0d: out=%h oe=%h irq=%b, required %h %h %b", n,
                         gpio_out, gpio_oe, irq, m_out[NG-1:0], m_dir[NG-1:0], |(m_stat & m_en));
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_ops();
        test_input_irq();
        test_w1c_race();
        test_decode();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
